// File: rtl/period_meter.sv
// Period meter: measures the period and high time of a slow asynchronous square
// wave in clk cycles, and reports the equivalent clock-divider setting.
module period_meter #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] TIMEOUT = 32'd100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] divisor_out,
  output logic             valid,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST_CNT = TIMEOUT - ONE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             s1, s2, s3;
  logic             rise;
  logic [WIDTH-1:0] cnt, hcnt;
  logic [WIDTH-1:0] div_calc;

  logic restart;   // load cnt/hcnt with 1 and (re)enter MEASURE
  logic capture;   // publish the just-completed period
  logic tick;      // count one more cycle of the current period
  logic stall_set;

  // Two flops for metastability, third for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Inverse of the divider: a divisor d toggles every d+1 cycles.
  assign div_calc = (cnt > ONE) ? ((cnt >> 1) - ONE) : '0;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    capture   = 1'b0;
    tick      = 1'b0;
    stall_set = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          restart   = 1'b1;
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          restart = 1'b1;
        end else if (cnt == LAST_CNT) begin
          stall_set = 1'b1;
          state_nxt = STALLED;
        end else begin
          tick = 1'b1;
        end
      end
      STALLED: begin
        // First edge after a stall only re-arms; its period is unknown.
        if (rise) begin
          restart   = 1'b1;
          state_nxt = MEASURE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      hcnt        <= '0;
      period      <= '0;
      high_time   <= '0;
      divisor_out <= '0;
      valid       <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        period      <= cnt;
        high_time   <= hcnt;
        divisor_out <= div_calc;
      end
      if (restart) begin
        cnt     <= ONE;
        hcnt    <= ONE;
        stalled <= 1'b0;
      end else if (tick) begin
        cnt  <= cnt + ONE;
        hcnt <= hcnt + {{(WIDTH-1){1'b0}}, s2};
      end
      if (stall_set) stalled <= 1'b1;
    end
  end

endmodule
